// File: rtl/mem_arbiter_nm.sv
// mem_arbiter_nm: N-way round-robin arbiter sequencing 1/2/4-byte transfers onto an 8-bit memory bus
module mem_arbiter_nm #(
    parameter int NUM_MASTERS    = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int RAM_ADDR_WIDTH = 17,
    parameter bit TOP_PRIO       = 1
) (
    input  logic                               clk_in,
    input  logic                               rst_in,
    input  logic                               rdy_in,
    input  logic [NUM_MASTERS-1:0]             m_req,
    input  logic [NUM_MASTERS-1:0]             m_wr,
    input  logic [2*NUM_MASTERS-1:0]           m_len,
    input  logic [ADDR_WIDTH*NUM_MASTERS-1:0]  m_addr,
    input  logic [32*NUM_MASTERS-1:0]          m_wdata,
    output logic [NUM_MASTERS-1:0]             m_done,
    output logic [31:0]                        m_rdata,
    output logic [ADDR_WIDTH-1:0]              mem_a,
    output logic                               mem_wr,
    output logic [7:0]                         mem_dout,
    input  logic [7:0]                         mem_din,
    output logic                               mem_io,
    output logic                               busy
);
    localparam int IW = $clog2(NUM_MASTERS);
    typedef enum logic [1:0] {IDLE, XFER, FIN, DONE} state_t;
    state_t state, state_n;
    logic [IW-1:0] rr_ptr, rr_n, win, win_n, grant;
    logic [IW:0] s;
    logic found, top, wr, wr_n, sel_wr, rdy_q;
    logic [1:0] sel_len, bidx;
    logic [2:0] lenb, lenb_n, cnt, cnt_n, off;
    logic [ADDR_WIDTH-1:0] base, base_n, sel_addr;
    logic [31:0] wdata, wdata_n, sel_wdata, rbuf, rbuf_n;
    logic [7:0] din_q, din_eff;
    // round-robin search from rr_ptr, overridden by the top-priority master when enabled
    always_comb begin
        found = 1'b0;
        grant = '0;
        s = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            s = {1'b0, rr_ptr} + (IW+1)'(i);
            if (s >= (IW+1)'(NUM_MASTERS)) s = s - (IW+1)'(NUM_MASTERS);
            if (!found && m_req[s[IW-1:0]]) begin
                grant = s[IW-1:0];
                found = 1'b1;
            end
        end
        top = TOP_PRIO && m_req[NUM_MASTERS-1];
        if (top) grant = IW'(NUM_MASTERS-1);
    end
    // mux the winning master's request fields
    always_comb begin
        sel_wr = 1'b0;
        sel_len = '0;
        sel_addr = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant == IW'(i)) begin
                sel_wr = m_wr[i];
                sel_len = m_len[2*i +: 2];
                sel_addr = m_addr[ADDR_WIDTH*i +: ADDR_WIDTH];
                sel_wdata = m_wdata[32*i +: 32];
            end
        end
    end
    // next-state logic: grant, byte sequencing and little-endian read assembly
    always_comb begin
        state_n = state;
        rr_n = rr_ptr;
        win_n = win;
        wr_n = wr;
        lenb_n = lenb;
        base_n = base;
        wdata_n = wdata;
        cnt_n = cnt;
        rbuf_n = rbuf;
        bidx = 2'(cnt - 3'd1);
        din_eff = rdy_q ? mem_din : din_q;
        if (state == IDLE && |m_req) begin
            state_n = XFER;
            win_n = grant;
            wr_n = sel_wr;
            lenb_n = sel_len == 2'd0 ? 3'd1 : sel_len == 2'd1 ? 3'd2 : 3'd4;
            base_n = sel_addr;
            wdata_n = sel_wdata;
            cnt_n = '0;
            rbuf_n = '0;
            if (!top) rr_n = grant == IW'(NUM_MASTERS-1) ? '0 : grant + IW'(1);
        end else if (state == XFER) begin
            cnt_n = cnt + 3'd1;
            if (!wr && cnt != 3'd0) rbuf_n = rbuf | (32'(din_eff) << {bidx, 3'b000});
            if (cnt == lenb - 3'd1) state_n = wr ? DONE : FIN;
        end else if (state == FIN) begin
            rbuf_n = rbuf | (32'(din_eff) << {bidx, 3'b000});
            state_n = DONE;
        end else if (state == DONE) begin
            state_n = IDLE;
        end
    end
    // bus and completion outputs; the address stays on the last byte once sequencing ends
    always_comb begin
        off = state == XFER ? cnt : cnt == 3'd0 ? 3'd0 : cnt - 3'd1;
        mem_a = base + ADDR_WIDTH'(off);
        mem_wr = rdy_in && state == XFER && wr;
        mem_dout = (state == XFER && wr) ? 8'(wdata >> {cnt[1:0], 3'b000}) : 8'h00;
        mem_io = mem_a[RAM_ADDR_WIDTH -: 2] == 2'b11;
        m_done = (rdy_in && state == DONE) ? NUM_MASTERS'(1) << win : '0;
        m_rdata = state == DONE ? rbuf : '0;
        busy = state != IDLE;
    end
    // state register; the bus byte arriving on the first paused cycle is kept so a stall cannot lose it
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= IDLE;
            rr_ptr <= '0;
            win <= '0;
            wr <= 1'b0;
            lenb <= 3'd1;
            base <= '0;
            wdata <= '0;
            cnt <= '0;
            rbuf <= '0;
            rdy_q <= 1'b1;
            din_q <= '0;
        end else begin
            rdy_q <= rdy_in;
            if (rdy_q) din_q <= mem_din;
            if (rdy_in) begin
                state <= state_n;
                rr_ptr <= rr_n;
                win <= win_n;
                wr <= wr_n;
                lenb <= lenb_n;
                base <= base_n;
                wdata <= wdata_n;
                cnt <= cnt_n;
                rbuf <= rbuf_n;
            end
        end
    end
endmodule
